user_module_seq_mac: RTL and testbench

Parametrised successor to the team's nibble multiplier user module. Operands are loaded nibble-by-nibble over the 8-bit pin interface. A multi-cycle shift-add multiply-accumulate runs on command, with overwrite/accumulate/saturate/clear modes. The accumulator is read back one byte at a time. The block sits behind the standard `io_in`/`io_out` user-module pins; the clock and reset are carried on `io_in` bits.

---
 rtl/user_module_seq_mac.sv | 157 +++++++++++++++
 tb/tb_user_module_seq_mac.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/user_module_seq_mac.sv
// -----------------------------------------------------------------------------
// user_module_seq_mac
//
// Nibble-loaded, multi-cycle shift-add multiply-accumulate behind the standard
// 8-bit user-module pin interface.
//
// Parameters
//   OPW  : operand width in bits. Must be a multiple of 4, from 4 to 16.
//   ACCW : accumulator width in bits. Must be a multiple of 8, with
//          2*OPW <= ACCW <= 32.
//
// Ports
//   io_in[0]   : clock. All state updates on its rising edge.
//   io_in[1]   : synchronous active-high reset.
//   io_in[3:2] : command. 00 SEL, 01 LOAD_A, 10 LOAD_B, 11 EXEC.
//   io_in[7:4] : data nibble.
//   io_out     : accumulator byte selected by rsel. Reads 0x00 when rsel
//                points past the top byte of the accumulator.
// -----------------------------------------------------------------------------
module user_module_seq_mac #(
  parameter int OPW  = 8,
  parameter int ACCW = 24
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int PW = 2 * OPW;
  localparam int CW = (OPW > 1) ? $clog2(OPW) : 1;

  localparam logic [1:0] CMD_SEL    = 2'b00;
  localparam logic [1:0] CMD_LOAD_A = 2'b01;
  localparam logic [1:0] CMD_LOAD_B = 2'b10;
  localparam logic [1:0] CMD_EXEC   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    ACC  = 2'b10
  } state_t;

  logic       clk;
  logic       rst;
  logic [1:0] cmd_s;
  logic [3:0] d_s;

  assign clk   = io_in[0];
  assign rst   = io_in[1];
  assign cmd_s = io_in[3:2];
  assign d_s   = io_in[7:4];

  state_t            state_r;
  logic [OPW-1:0]    a_r;
  logic [OPW-1:0]    b_r;
  logic [OPW-1:0]    mcand_r;
  logic [OPW-1:0]    mplier_r;
  logic [PW-1:0]     prod_r;
  logic [ACCW-1:0]   acc_r;
  logic [CW-1:0]     cnt_r;
  logic              mode_acc_r;
  logic              mode_sat_r;
  logic [1:0]        rsel_r;

  logic [PW-1:0]     addend_s;
  logic [ACCW:0]     sum_s;
  logic [31:0]       acc_pad_s;

  // Shift a nibble into the low end of an operand, dropping the top nibble.
  // The cast keeps the low OPW bits, so OPW=4 degenerates to a plain load.
  function automatic logic [OPW-1:0] shift_in_nibble(
    input logic [OPW-1:0] cur,
    input logic [3:0]     nib
  );
    return OPW'({cur, nib});
  endfunction

  // Datapath helpers: shifted partial product and accumulate sum with carry.
  always_comb begin
    addend_s = PW'(mcand_r) << cnt_r;
    sum_s    = (ACCW + 1)'(acc_r) + (ACCW + 1)'(prod_r);
  end

  // Byte readback: bytes above ACCW in the 32-bit padded view are zero, which
  // gives the 0x00 result for out-of-range rsel without a separate compare.
  always_comb begin
    acc_pad_s = 32'(acc_r);
    io_out    = acc_pad_s[{rsel_r, 3'b000} +: 8];
  end

  // Control FSM and all architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      mcand_r    <= '0;
      mplier_r   <= '0;
      prod_r     <= '0;
      acc_r      <= '0;
      cnt_r      <= '0;
      mode_acc_r <= 1'b0;
      mode_sat_r <= 1'b0;
      rsel_r     <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          case (cmd_s)
            CMD_SEL:    rsel_r <= d_s[1:0];
            CMD_LOAD_A: a_r    <= shift_in_nibble(a_r, d_s);
            CMD_LOAD_B: b_r    <= shift_in_nibble(b_r, d_s);
            CMD_EXEC: begin
              // Clear wins over start; d[3] is reserved and never looked at.
              if (d_s[1]) begin
                acc_r <= '0;
              end else begin
                mcand_r    <= a_r;
                mplier_r   <= b_r;
                prod_r     <= '0;
                cnt_r      <= '0;
                mode_acc_r <= d_s[0];
                mode_sat_r <= d_s[2];
                state_r    <= MUL;
              end
            end
            default: ;
          endcase
        end

        MUL: begin
          // One multiplier bit per cycle, LSB first, no early exit on zero.
          if (mplier_r[cnt_r]) begin
            prod_r <= prod_r + addend_s;
          end
          if (cnt_r == CW'(OPW - 1)) begin
            state_r <= ACC;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end

        ACC: begin
          if (!mode_acc_r) begin
            acc_r <= ACCW'(prod_r);
          end else if (mode_sat_r && sum_s[ACCW]) begin
            acc_r <= '1;
          end else begin
            acc_r <= sum_s[ACCW-1:0];
          end
          state_r <= IDLE;
        end

        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_module_seq_mac.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for user_module_seq_mac. Three instances share
// one clock: u0 (OPW=8, ACCW=24), u1 (OPW=8, ACCW=16), u2 (OPW=4, ACCW=8).
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point, so every check sees the state after the preceding edge.
// -----------------------------------------------------------------------------
module tb_user_module_seq_mac;

  localparam logic [1:0] SEL = 2'b00;
  localparam logic [1:0] LDA = 2'b01;
  localparam logic [1:0] LDB = 2'b10;
  localparam logic [1:0] EXE = 2'b11;

  logic       clk = 1'b0;
  logic [6:0] ctl [3];      // {d, cmd, rst} per instance
  logic [1:0] cur_rsel [3]; // rsel each instance holds while idling
  logic [7:0] in0, in1, in2;
  logic [7:0] out0, out1, out2;
  int         n_checks = 0;
  int         n_pass   = 0;

  assign in0 = {ctl[0], clk};
  assign in1 = {ctl[1], clk};
  assign in2 = {ctl[2], clk};

  user_module_seq_mac #(.OPW(8), .ACCW(24)) u0 (.io_in(in0), .io_out(out0));
  user_module_seq_mac #(.OPW(8), .ACCW(16)) u1 (.io_in(in1), .io_out(out1));
  user_module_seq_mac #(.OPW(4), .ACCW(8))  u2 (.io_in(in2), .io_out(out2));

  always #5 clk = ~clk;

  function automatic logic [7:0] out_of(input int w);
    case (w)
      0:       return out0;
      1:       return out1;
      default: return out2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Drive one instance for one edge; the others sit on SEL of their own rsel.
  task automatic tick(input int w, input logic r, input logic [1:0] c, input logic [3:0] d);
    for (int i = 0; i < 3; i++) begin
      ctl[i] = {2'b00, cur_rsel[i], SEL, 1'b0};
    end
    ctl[w] = {d, c, r};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int w);
    tick(w, 1'b0, SEL, {2'b00, cur_rsel[w]});
  endtask

  task automatic sel(input int w, input logic [1:0] v);
    cur_rsel[w] = v;
    tick(w, 1'b0, SEL, {2'b00, v});
  endtask

  task automatic load(input int w, input logic [1:0] c, input logic [3:0] hi, input logic [3:0] lo);
    tick(w, 1'b0, c, hi);
    tick(w, 1'b0, c, lo);
  endtask

  task automatic run(input int w, input logic [3:0] d, input int opw);
    tick(w, 1'b0, EXE, d);
    repeat (opw + 1) idle(w);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cur_rsel[i] = 2'b00;
      ctl[i]      = {4'hF, EXE, 1'b1};
    end
    repeat (2) @(posedge clk);
    #1;
    // 1. Reset with EXEC/clear garbage on the pins
    check("rst_u0", out0, 8'h00);
    check("rst_u1", out1, 8'h00);
    check("rst_u2", out2, 8'h00);
    sel(0, 2'd2);
    check("rst_sel2", out0, 8'h00);
    sel(0, 2'd0);

    // 2. Overwrite multiply 0x12 * 0x03 = 0x36, latency check
    load(0, LDA, 4'h1, 4'h2);
    load(0, LDB, 4'h0, 4'h3);
    tick(0, 1'b0, EXE, 4'b0000);
    for (int k = 1; k <= 8; k++) begin
      idle(0);
      check($sformatf("busy_e%0d", k), out0, 8'h00);
    end
    idle(0);
    check("ovw_e9", out0, 8'h36);

    // 3. Accumulate 0x36 + 0xFF*0xFF = 0xFE37, byte readback
    load(0, LDA, 4'hF, 4'hF);
    load(0, LDB, 4'hF, 4'hF);
    run(0, 4'b0001, 8);
    check("acc_b0", out0, 8'h37);
    sel(0, 2'd1);
    check("acc_b1", out0, 8'hFE);
    sel(0, 2'd2);
    check("acc_b2", out0, 8'h00);
    sel(0, 2'd3);
    check("acc_b3", out0, 8'h00);
    sel(0, 2'd0);

    // 4. Wrap vs saturate on ACCW=16
    load(1, LDA, 4'h1, 4'h2);
    load(1, LDB, 4'h0, 4'h3);
    run(1, 4'b0000, 8);
    load(1, LDA, 4'hF, 4'hF);
    load(1, LDB, 4'hF, 4'hF);
    run(1, 4'b0001, 8);
    check("w16_pre_b0", out1, 8'h37);
    run(1, 4'b0001, 8);
    check("wrap_b0", out1, 8'h38);
    sel(1, 2'd1);
    check("wrap_b1", out1, 8'hFC);
    sel(1, 2'd2);
    check("w16_rsel2", out1, 8'h00);
    sel(1, 2'd0);
    tick(1, 1'b0, EXE, 4'b0010);
    load(1, LDA, 4'h1, 4'h2);
    load(1, LDB, 4'h0, 4'h3);
    run(1, 4'b0000, 8);
    load(1, LDA, 4'hF, 4'hF);
    load(1, LDB, 4'hF, 4'hF);
    run(1, 4'b0001, 8);
    run(1, 4'b0101, 8);
    check("sat_b0", out1, 8'hFF);
    sel(1, 2'd1);
    check("sat_b1", out1, 8'hFF);
    // Clear with d[0] and reserved d[3] also set: clear wins, no MUL
    tick(1, 1'b0, EXE, 4'b1011);
    check("clr_u1", out1, 8'h00);
    sel(1, 2'd0);
    check("clr_u1_b0", out1, 8'h00);

    // 5. Busy: LOAD_A at E+3 ignored, product stays 0xFF*0xFF = 0xFE01
    tick(0, 1'b0, EXE, 4'b0000);
    idle(0);
    idle(0);
    tick(0, 1'b0, LDA, 4'h9);
    repeat (6) idle(0);
    check("busy_b0", out0, 8'h01);
    run(0, 4'b0000, 8);
    check("rerun_b0", out0, 8'h01);
    sel(0, 2'd1);
    check("rerun_b1", out0, 8'hFE);
    sel(0, 2'd0);
    // Abort: reset at E+4, then LOAD_A must be taken at the next edge
    tick(0, 1'b0, EXE, 4'b0000);
    repeat (3) idle(0);
    cur_rsel[0] = 2'd0;
    tick(0, 1'b1, SEL, 4'h0);
    check("abort_acc", out0, 8'h00);
    tick(0, 1'b0, LDA, 4'h5);
    load(0, LDB, 4'h0, 4'h2);
    run(0, 4'b0000, 8);
    check("post_abort", out0, 8'h0A);
    tick(0, 1'b0, EXE, 4'b0010);
    check("clr_u0", out0, 8'h00);

    // 6. OPW=4 instance: 3*7 = 21 after 5 edges, 15*15 = 225
    tick(2, 1'b0, LDA, 4'h3);
    tick(2, 1'b0, LDB, 4'h7);
    tick(2, 1'b0, EXE, 4'b0000);
    repeat (4) idle(2);
    check("o4_e4", out2, 8'h00);
    idle(2);
    check("o4_e5", out2, 8'h15);
    tick(2, 1'b0, LDA, 4'hF);
    tick(2, 1'b0, LDB, 4'hF);
    run(2, 4'b0000, 4);
    check("o4_225", out2, 8'hE1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
